gpr_sb_regfile: RTL and testbench

Parametrised general-purpose register file with two asynchronous read ports, one byte-enabled synchronous write port, optional hardwired-zero register, optional write-to-read bypass, and a per-register busy scoreboard for pipelined writeback. It replaces the fixed 32x32 GPR in the datapath. The decode stage marks destination registers busy at issue. The writeback stage clears them. Hazard logic consumes the busy flags.

---
 rtl/gpr_sb_regfile.sv | 107 ++++++++++
 tb/tb_gpr_sb_regfile.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gpr_sb_regfile.sv
// General-purpose register file: two combinational read ports, one byte-enabled write port,
// optional hardwired-zero r0, optional write-to-read bypass and a per-register busy scoreboard.
module gpr_sb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   RReg1,
    input  logic [ADDR_W-1:0]   RReg2,
    output logic [DATA_W-1:0]   RData1,
    output logic [DATA_W-1:0]   RData2,
    output logic                Busy1,
    output logic                Busy2,
    input  logic [ADDR_W-1:0]   WReg,
    input  logic                RegWrite,
    input  logic [DATA_W-1:0]   WData,
    input  logic [DATA_W/8-1:0] WByteEn,
    input  logic                IssueValid,
    input  logic [ADDR_W-1:0]   IssueReg,
    output logic [ADDR_W:0]     BusyCount,
    output logic                IssueErr
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;
    logic              r_issue_err;

    logic              w_wr_eff;
    logic              w_iss_eff;
    logic              w_iss_err;
    logic [DATA_W-1:0] w_wmerge;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_rbusy [2];

    // Writes and issues targeting a hardwired r0 are dropped entirely.
    assign w_wr_eff  = RegWrite   && !(ZERO_REG && (WReg == '0));
    assign w_iss_eff = IssueValid && !(ZERO_REG && (IssueReg == '0));
    assign w_iss_err = w_iss_eff && r_busy[IssueReg] && !(w_wr_eff && (WReg == IssueReg));

    always_comb begin
        w_wmerge = r_mem[WReg];
        for (int k = 0; k < NBYTES; k++) begin
            if (WByteEn[k]) w_wmerge[8*k +: 8] = WData[8*k +: 8];
        end
    end

    // Clear by writeback first, then set by issue so a same-cycle issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_eff)  w_busy_nxt[WReg]     = 1'b0;
        if (w_iss_eff) w_busy_nxt[IssueReg] = 1'b1;
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    assign w_raddr[0] = RReg1;
    assign w_raddr[1] = RReg2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_mem[w_raddr[p]];
            w_rbusy[p] = r_busy[w_raddr[p]];
            if (BYPASS && w_wr_eff && (w_raddr[p] == WReg)) begin
                w_rdata[p] = w_wmerge;
                w_rbusy[p] = w_iss_eff && (IssueReg == WReg);
            end
            if (ZERO_REG && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
                w_rbusy[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy      <= '0;
            r_busy_cnt  <= '0;
            r_issue_err <= 1'b0;
        end else begin
            if (w_wr_eff) r_mem[WReg] <= w_wmerge;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
            if (w_iss_err) r_issue_err <= 1'b1;
        end
    end

    assign RData1    = w_rdata[0];
    assign RData2    = w_rdata[1];
    assign Busy1     = w_rbusy[0];
    assign Busy2     = w_rbusy[1];
    assign BusyCount = r_busy_cnt;
    assign IssueErr  = r_issue_err;

endmodule

// File: tb/tb_gpr_sb_regfile.sv
// Directed bench for gpr_sb_regfile: instance A uses bypass, instance B has bypass disabled;
// both share the same stimulus.
module tb_gpr_sb_regfile;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  RReg1, RReg2, WReg, IssueReg;
    logic        RegWrite, IssueValid;
    logic [31:0] WData;
    logic [3:0]  WByteEn;

    logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic        a_busy1, a_busy2, b_busy1, b_busy2;
    logic [5:0]  a_cnt, b_cnt;
    logic        a_err, b_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    gpr_sb_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
        .Clk(Clk), .Reset(Reset), .RReg1(RReg1), .RReg2(RReg2),
        .RData1(a_rdata1), .RData2(a_rdata2), .Busy1(a_busy1), .Busy2(a_busy2),
        .WReg(WReg), .RegWrite(RegWrite), .WData(WData), .WByteEn(WByteEn),
        .IssueValid(IssueValid), .IssueReg(IssueReg), .BusyCount(a_cnt), .IssueErr(a_err)
    );

    gpr_sb_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
        .Clk(Clk), .Reset(Reset), .RReg1(RReg1), .RReg2(RReg2),
        .RData1(b_rdata1), .RData2(b_rdata2), .Busy1(b_busy1), .Busy2(b_busy2),
        .WReg(WReg), .RegWrite(RegWrite), .WData(WData), .WByteEn(WByteEn),
        .IssueValid(IssueValid), .IssueReg(IssueReg), .BusyCount(b_cnt), .IssueErr(b_err)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0; IssueValid = 1'b0; WByteEn = 4'h0; WData = '0;
        WReg = '0; IssueReg = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; idle(); RReg1 = '0; RReg2 = '0;
        step(); step();
        Reset = 1'b0;
        step();
        for (int i = 0; i < 32; i++) begin
            RReg1 = 5'(i); RReg2 = 5'(31 - i);
            #1;
            n_cmp++; if (a_rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 r%0d: got %h want 00000000", i, a_rdata1); end
            n_cmp++; if (a_rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2 r%0d: got %h want 00000000", 31 - i, a_rdata2); end
            n_cmp++; if ({a_busy1, a_busy2, b_busy1, b_busy2} !== 4'b0) begin n_fail++; $display("FAIL reset_busy r%0d: got %b want 0000", i, {a_busy1, a_busy2, b_busy1, b_busy2}); end
        end
        n_cmp++; if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busycount: got %0d want 0", a_cnt); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_issueerr: got %b want 0", a_err); end
    endtask

    task automatic test_reset_mid_write();
        RegWrite = 1'b1; WReg = 5'd5; WData = 32'h12345678; WByteEn = 4'hF;
        step(); idle(); RReg1 = 5'd5; #1;
        n_cmp++; if (b_rdata1 !== 32'h12345678) begin n_fail++; $display("FAIL prewrite_r5: got %h want 12345678", b_rdata1); end
        RegWrite = 1'b1; WReg = 5'd5; WData = 32'hDEADBEEF; WByteEn = 4'hF;
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (a_rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midreset_bypass_r5: got %h want deadbeef", a_rdata1); end
        n_cmp++; if (b_rdata1 !== 32'h0) begin n_fail++; $display("FAIL midreset_async_r5: got %h want 00000000", b_rdata1); end
        step();
        Reset = 1'b0; idle(); #1;
        n_cmp++; if (a_rdata1 !== 32'h0) begin n_fail++; $display("FAIL midreset_r5: got %h want 00000000", a_rdata1); end
        step();
        n_cmp++; if (b_rdata1 !== 32'h0) begin n_fail++; $display("FAIL midreset_r5_later: got %h want 00000000", b_rdata1); end
    endtask

    task automatic test_byte_write();
        RReg1 = 5'd3;
        RegWrite = 1'b1; WReg = 5'd3; WData = 32'h11223344; WByteEn = 4'hF;
        step();
        WData = 32'hAABBCCDD; WByteEn = 4'h5; #1;
        n_cmp++; if (a_rdata1 !== 32'h11BB33DD) begin n_fail++; $display("FAIL bytewr_bypass: got %h want 11bb33dd", a_rdata1); end
        n_cmp++; if (b_rdata1 !== 32'h11223344) begin n_fail++; $display("FAIL bytewr_nobypass: got %h want 11223344", b_rdata1); end
        step(); idle(); RReg2 = 5'd3; #1;
        n_cmp++; if (a_rdata2 !== 32'h11BB33DD) begin n_fail++; $display("FAIL bytewr_r3: got %h want 11bb33dd", a_rdata2); end
        n_cmp++; if (b_rdata1 !== 32'h11BB33DD) begin n_fail++; $display("FAIL bytewr_r3_b: got %h want 11bb33dd", b_rdata1); end
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; WReg = 5'd0; WData = 32'hFFFFFFFF; WByteEn = 4'hF;
        IssueValid = 1'b1; IssueReg = 5'd0; RReg1 = 5'd0;
        #1;
        n_cmp++; if (a_rdata1 !== 32'h0 || a_busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_samecycle: got %h/%b want 00000000/0", a_rdata1, a_busy1); end
        step(); idle(); #1;
        n_cmp++; if (a_rdata1 !== 32'h0) begin n_fail++; $display("FAIL zero_rdata: got %h want 00000000", a_rdata1); end
        n_cmp++; if (a_busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", a_busy1); end
        n_cmp++; if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL zero_busycount: got %0d want 0", a_cnt); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL zero_issueerr: got %b want 0", a_err); end
    endtask

    task automatic test_bypass();
        // Write old value and issue r7 together: r7 ends up busy holding 01020304.
        RegWrite = 1'b1; WReg = 5'd7; WData = 32'h01020304; WByteEn = 4'hF;
        IssueValid = 1'b1; IssueReg = 5'd7;
        step(); idle(); RReg1 = 5'd7; RReg2 = 5'd3; #1;
        n_cmp++; if (a_busy1 !== 1'b1 || a_cnt !== 6'd1) begin n_fail++; $display("FAIL bypass_setup: got busy %b cnt %0d want 1 1", a_busy1, a_cnt); end
        RegWrite = 1'b1; WReg = 5'd7; WData = 32'h5A5A5A5A; WByteEn = 4'hF; #1;
        n_cmp++; if (a_rdata1 !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL bypass_rdata: got %h want 5a5a5a5a", a_rdata1); end
        n_cmp++; if (a_busy1 !== 1'b0) begin n_fail++; $display("FAIL bypass_busy: got %b want 0", a_busy1); end
        n_cmp++; if (b_rdata1 !== 32'h01020304) begin n_fail++; $display("FAIL nobypass_rdata: got %h want 01020304", b_rdata1); end
        n_cmp++; if (b_busy1 !== 1'b1) begin n_fail++; $display("FAIL nobypass_busy: got %b want 1", b_busy1); end
        n_cmp++; if (a_rdata2 !== 32'h11BB33DD) begin n_fail++; $display("FAIL bypass_port2_indep: got %h want 11bb33dd", a_rdata2); end
        IssueValid = 1'b1; IssueReg = 5'd7; #1;
        n_cmp++; if (a_busy1 !== 1'b1) begin n_fail++; $display("FAIL bypass_busy_reissue: got %b want 1", a_busy1); end
        IssueValid = 1'b0; #1;
        step(); idle(); #1;
        n_cmp++; if (b_rdata1 !== 32'h5A5A5A5A || b_busy1 !== 1'b0) begin n_fail++; $display("FAIL bypass_after: got %h/%b want 5a5a5a5a/0", b_rdata1, b_busy1); end
        n_cmp++; if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL bypass_busycount: got %0d want 0", a_cnt); end
    endtask

    task automatic test_scoreboard();
        logic [4:0] regs [3];
        regs[0] = 5'd4; regs[1] = 5'd9; regs[2] = 5'd12;
        for (int i = 0; i < 3; i++) begin
            IssueValid = 1'b1; IssueReg = regs[i];
            step();
            n_cmp++; if (a_cnt !== 6'(i + 1)) begin n_fail++; $display("FAIL issue_count_%0d: got %0d want %0d", i, a_cnt, i + 1); end
        end
        idle();
        // Write with no bytes enabled still retires r9.
        RegWrite = 1'b1; WReg = 5'd9; WData = 32'hCAFEF00D; WByteEn = 4'h0;
        step(); idle(); RReg1 = 5'd9; RReg2 = 5'd4; #1;
        n_cmp++; if (a_cnt !== 6'd2) begin n_fail++; $display("FAIL clear_count: got %0d want 2", a_cnt); end
        n_cmp++; if (a_busy1 !== 1'b0 || b_busy1 !== 1'b0) begin n_fail++; $display("FAIL clear_busy_r9: got %b%b want 00", a_busy1, b_busy1); end
        n_cmp++; if (a_rdata1 !== 32'h0) begin n_fail++; $display("FAIL clear_noen_data: got %h want 00000000", a_rdata1); end
        n_cmp++; if (a_busy2 !== 1'b1) begin n_fail++; $display("FAIL still_busy_r4: got %b want 1", a_busy2); end
    endtask

    task automatic test_issue_err();
        IssueValid = 1'b1; IssueReg = 5'd6;
        step();
        RegWrite = 1'b1; WReg = 5'd6; WData = 32'h66; WByteEn = 4'hF;
        step(); idle(); RReg1 = 5'd6; #1;
        n_cmp++; if (a_busy1 !== 1'b1 || a_cnt !== 6'd3) begin n_fail++; $display("FAIL issue_write_same: got busy %b cnt %0d want 1 3", a_busy1, a_cnt); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL issue_write_noerr: got %b want 0", a_err); end
        IssueValid = 1'b1; IssueReg = 5'd4;
        #1;
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_before_edge: got %b want 0", a_err); end
        step(); idle();
        n_cmp++; if (a_err !== 1'b1 || b_err !== 1'b1) begin n_fail++; $display("FAIL double_issue_err: got %b%b want 11", a_err, b_err); end
        n_cmp++; if (a_cnt !== 6'd3) begin n_fail++; $display("FAIL double_issue_count: got %0d want 3", a_cnt); end
        RegWrite = 1'b1; WReg = 5'd4; WByteEn = 4'hF; WData = 32'h44;
        step();
        WReg = 5'd12;
        step();
        WReg = 5'd6;
        step(); idle();
        n_cmp++; if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", a_cnt); end
        n_cmp++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", a_err); end
        Reset = 1'b1; #1;
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b want 0", a_err); end
        step(); Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_byte_write();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_issue_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
